cu_seq: RTL and testbench
=========================

Name: cu_seq

Overview:
Parametrised, sequential successor to the combinational instruction decoder. Accepts instructions over a valid/ready handshake and latches the decoded fields. Issues exactly-timed ALU / load-immediate / memory enables, holding memory enables until the memory acknowledges or a timeout expires. Flags illegal opcodes and counts retired instructions. Sits between instruction fetch and the register file / ALU / data memory.

Parameters:
OPC_W, 4, opcode field width
REG_W, 3, register-address field width (op1, op2, op3)
IMM_W, 8, immediate field width
INSTR_W, OPC_W+3*REG_W+IMM_W (21), instruction width; derived, not overridable
MEM_TIMEOUT, 16, max MEM cycles without mem_done before abort (>=2)
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset: asynchronous, active-low
instr_valid  in  1  instruction present
instr_ready  out  1  block can accept this cycle
instruction  in  INSTR_W  {opcode, op1, op2, op3, imm}, MSB first
mem_done  in  1  memory access complete
opcode  out  OPC_W  latched opcode
op1/op2/op3  out  REG_W each  latched register fields
load_immediate_data  out  IMM_W  latched immediate
alu_enable  out  1  ALU op issue
load_immediate_enable  out  1  load-immediate issue
memory_read_enable  out  1  memory read request
memory_write_enable  out  1  memory write request
illegal_op  out  1  one-cycle pulse, undefined opcode
mem_timeout  out  1  one-cycle pulse, memory access aborted
retired_count  out  CNT_W  completed-instruction count

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs, fields, counters = 0. instr_ready reads 1 once in IDLE.
- Opcode classes: 0000–0110 ALU; 1000 LI; 1001 MRD; 1010 MWR. All other codes (0111, 1011–1111) are ILLEGAL.
- Accept: instr_valid && instr_ready at a clock edge. Latch all fields. Field outputs hold until the next accept.
- States: IDLE, EXEC, MEM.
- Transitions on accept:
  - ALU, LI, ILLEGAL go to EXEC.
  - MRD, MWR go to MEM, with timeout counter = 0.
- EXEC (exactly 1 cycle):
  - ALU asserts alu_enable; LI asserts load_immediate_enable.
  - ILLEGAL asserts illegal_op only; no enables.
  - instr_ready = 1 in EXEC, so back-to-back non-memory instructions are accepted every cycle.
  - Next state: the accepted instruction's target state if an accept occurs, else IDLE.
- MEM:
  - memory_read_enable or memory_write_enable held high for every MEM cycle; instr_ready = 0.
  - mem_done=1 ends MEM: the enable is still high that cycle; next state IDLE.
  - Else if counter == MEM_TIMEOUT-1, go to IDLE and pulse mem_timeout in the following (IDLE) cycle.
  - Else counter increments.
- mem_done outside MEM is ignored.
- Enables are mutually exclusive and registered-state-derived (no combinational path from instruction).
- retired_count:
  - +1 on leaving EXEC for ALU/LI, and on leaving MEM via mem_done.
  - Not incremented for ILLEGAL or timeout.
  - Wraps modulo 2^CNT_W.
- Reset mid-MEM: enables drop immediately (async); no mem_timeout pulse; counter cleared.

Decomposition:
- Shared package cu_pkg:
  - opcode localparams (OPC_ALU_MIN/MAX, OPC_LI, OPC_MRD, OPC_MWR);
  - state enum (IDLE/EXEC/MEM);
  - INSTR_W derivation.
- One natural sub-module: cu_opclass (combinational opcode → class: alu/li/mrd/mwr/illegal). Reused by the future pipelined decoder. FSM, timeout counter and retire counter stay in cu_seq.

Test Plan:
- Reset then ALU: assert rst_n low mid-run, then release. Drive instruction=21'h005300 (opc 0, op1=1, op2=2, op3=3) valid for 1 cycle → next cycle alu_enable=1 for exactly 1 cycle, op1/op2/op3=1/2/3, retired_count=1.
- Back-to-back: three ALU opcodes 0001/0010/0011 on consecutive cycles, valid held → instr_ready stays 1, alu_enable high 3 consecutive cycles, retired_count=3.
- LI: instruction=21'h1140A5 → load_immediate_enable 1 cycle, op1=5, load_immediate_data=8'hA5.
- MRD with done: instruction=21'h12A000, mem_done raised on 4th MEM cycle → memory_read_enable high 4 cycles, instr_ready=0 throughout, retired_count+1, no mem_timeout.
- MWR timeout: opcode 1010, mem_done held 0 → memory_write_enable high exactly MEM_TIMEOUT=16 cycles, then mem_timeout 1-cycle pulse, retired_count unchanged, instr_ready=1.
- Illegal: instruction=21'h0E0000 (opc 0111) → illegal_op 1 cycle, all enables 0, retired_count unchanged. Then assert rst_n=0 during a MEM access → enables 0 immediately.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the sequential control unit:
// opcode map, FSM states, opcode class bundle.
package cu_pkg;

  localparam int OPC_ALU_MIN = 0;
  localparam int OPC_ALU_MAX = 6;
  localparam int OPC_LI      = 8;
  localparam int OPC_MRD     = 9;
  localparam int OPC_MWR     = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2
  } state_e;

  typedef struct packed {
    logic alu;
    logic li;
    logic mrd;
    logic mwr;
    logic ill;
  } opclass_t;

  function automatic int instr_w(
    input int opc_w,
    input int reg_w,
    input int imm_w
  );
    return opc_w + 3 * reg_w + imm_w;
  endfunction

endpackage

// File: rtl/cu_opclass.sv
// Combinational opcode classifier: alu / li / mrd / mwr / illegal.
// Exactly one class bit is set for any opcode.
module cu_opclass
  import cu_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opc,
  output opclass_t         cls
);

  localparam logic [OPC_W-1:0] C_ALU_MAX = OPC_W'(OPC_ALU_MAX);
  localparam logic [OPC_W-1:0] C_LI      = OPC_W'(OPC_LI);
  localparam logic [OPC_W-1:0] C_MRD     = OPC_W'(OPC_MRD);
  localparam logic [OPC_W-1:0] C_MWR     = OPC_W'(OPC_MWR);

  logic w_alu;

  // ALU range starts at opcode zero, so only the upper bound matters
  assign w_alu = (opc <= C_ALU_MAX);

  always_comb begin
    cls = '0;
    unique case (1'b1)
      w_alu:        cls.alu = 1'b1;
      (opc == C_LI):  cls.li  = 1'b1;
      (opc == C_MRD): cls.mrd = 1'b1;
      (opc == C_MWR): cls.mwr = 1'b1;
      default:      cls.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/cu_seq.sv
// Sequential control unit: latches decoded fields on a valid/ready
// accept, issues timed ALU/LI/memory enables, counts retirements.
module cu_seq
  import cu_pkg::*;
#(
  parameter int OPC_W       = 4,
  parameter int REG_W       = 3,
  parameter int IMM_W       = 8,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16,
  localparam int INSTR_W    = instr_w(OPC_W, REG_W, IMM_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_done,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   op1,
  output logic [REG_W-1:0]   op2,
  output logic [REG_W-1:0]   op3,
  output logic [IMM_W-1:0]   load_immediate_data,
  output logic               alu_enable,
  output logic               load_immediate_enable,
  output logic               memory_read_enable,
  output logic               memory_write_enable,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   retired_count
);

  localparam int TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e             r_state;
  opclass_t           r_cls;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_tmo_pulse;
  logic [CNT_W-1:0]   r_ret;
  logic [OPC_W-1:0]   r_opc;
  logic [REG_W-1:0]   r_op1;
  logic [REG_W-1:0]   r_op2;
  logic [REG_W-1:0]   r_op3;
  logic [IMM_W-1:0]   r_imm;

  opclass_t           w_cls;
  logic [OPC_W-1:0]   w_opc;
  logic               w_in_mem;
  logic               w_in_exec;
  logic               w_acc;
  logic               w_tmo_hit;
  logic               w_retire;

  assign w_opc = instruction[INSTR_W-1 -: OPC_W];

  cu_opclass #(
    .OPC_W (OPC_W)
  ) u_opclass (
    .opc (w_opc),
    .cls (w_cls)
  );

  assign w_in_mem  = (r_state == ST_MEM);
  assign w_in_exec = (r_state == ST_EXEC);
  assign w_acc     = instr_valid && instr_ready;
  assign w_tmo_hit = w_in_mem && !mem_done && (r_tmo == TMO_LAST);
  assign w_retire  = (w_in_exec && (r_cls.alu || r_cls.li))
                  || (w_in_mem && mem_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cls       <= '0;
      r_tmo       <= '0;
      r_tmo_pulse <= 1'b0;
      r_ret       <= '0;
      r_opc       <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_op3       <= '0;
      r_imm       <= '0;
    end else begin
      r_tmo_pulse <= w_tmo_hit;
      if (w_retire)
        r_ret <= r_ret + 1'b1;
      if (w_acc) begin
        r_cls <= w_cls;
        r_tmo <= '0;
        r_opc <= w_opc;
        r_op1 <= instruction[INSTR_W-OPC_W-1 -: REG_W];
        r_op2 <= instruction[IMM_W+2*REG_W-1 -: REG_W];
        r_op3 <= instruction[IMM_W+REG_W-1 -: REG_W];
        r_imm <= instruction[IMM_W-1:0];
      end else if (w_in_mem && !mem_done) begin
        r_tmo <= r_tmo + 1'b1;
      end
      unique case (r_state)
        ST_MEM: begin
          if (mem_done || w_tmo_hit)
            r_state <= ST_IDLE;
        end
        default: begin
          if (w_acc)
            r_state <= (w_cls.mrd || w_cls.mwr) ? ST_MEM : ST_EXEC;
          else
            r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready           = !w_in_mem;
  assign alu_enable            = w_in_exec && r_cls.alu;
  assign load_immediate_enable = w_in_exec && r_cls.li;
  assign illegal_op            = w_in_exec && r_cls.ill;
  assign memory_read_enable    = w_in_mem && r_cls.mrd;
  assign memory_write_enable   = w_in_mem && r_cls.mwr;
  assign mem_timeout           = r_tmo_pulse;
  assign retired_count         = r_ret;
  assign opcode                = r_opc;
  assign op1                   = r_op1;
  assign op2                   = r_op2;
  assign op3                   = r_op3;
  assign load_immediate_data   = r_imm;

endmodule

// File: tb/tb_cu_seq.sv
// Bench for cu_seq: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_cu_seq;

  localparam int TO = 16;
  localparam int K_ALU = 0;
  localparam int K_LI  = 1;
  localparam int K_MRD = 2;
  localparam int K_MWR = 3;
  localparam int K_ILL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        mem_done = 1'b0;
  logic [20:0] instruction = '0;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic [2:0]  op1, op2, op3;
  logic [7:0]  load_immediate_data;
  logic        alu_enable, load_immediate_enable;
  logic        memory_read_enable, memory_write_enable;
  logic        illegal_op, mem_timeout;
  logic [15:0] retired_count;

  cu_seq dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .instr_valid           (instr_valid),
    .instr_ready           (instr_ready),
    .instruction           (instruction),
    .mem_done              (mem_done),
    .opcode                (opcode),
    .op1                   (op1),
    .op2                   (op2),
    .op3                   (op3),
    .load_immediate_data   (load_immediate_data),
    .alu_enable            (alu_enable),
    .load_immediate_enable (load_immediate_enable),
    .memory_read_enable    (memory_read_enable),
    .memory_write_enable   (memory_write_enable),
    .illegal_op            (illegal_op),
    .mem_timeout           (mem_timeout),
    .retired_count         (retired_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int classify(input int o);
    if (o <= 6) return K_ALU;
    if (o == 8) return K_LI;
    if (o == 9) return K_MRD;
    if (o == 10) return K_MWR;
    return K_ILL;
  endfunction

  // Model: busy is 0 idle, 1 one-cycle execute, 2 memory access.
  // m_age counts memory cycles elapsed including the current one.
  int          m_busy = 0;
  int          m_kind = K_ILL;
  int          m_age = 0;
  logic        m_tmo = 1'b0;
  logic [15:0] m_ret = '0;
  logic [3:0]  m_opc = '0;
  logic [2:0]  m_op1 = '0, m_op2 = '0, m_op3 = '0;
  logic [7:0]  m_imm = '0;

  always @(negedge clk) begin : monitor
    bit acc;
    if (!rst_n) begin
      m_busy = 0; m_kind = K_ILL; m_age = 0; m_tmo = 1'b0;
      m_ret = '0; m_opc = '0; m_op1 = '0; m_op2 = '0;
      m_op3 = '0; m_imm = '0;
    end
    chk("ready", instr_ready, m_busy != 2);
    chk("alu_en", alu_enable, m_busy == 1 && m_kind == K_ALU);
    chk("li_en", load_immediate_enable, m_busy == 1 && m_kind == K_LI);
    chk("ill", illegal_op, m_busy == 1 && m_kind == K_ILL);
    chk("rd_en", memory_read_enable, m_busy == 2 && m_kind == K_MRD);
    chk("wr_en", memory_write_enable, m_busy == 2 && m_kind == K_MWR);
    chk("tmo", mem_timeout, m_tmo);
    chk("retired", retired_count, m_ret);
    chk("fields", {opcode, op1, op2, op3, load_immediate_data},
        {m_opc, m_op1, m_op2, m_op3, m_imm});
    if (rst_n) begin
      acc = instr_valid && (m_busy != 2);
      m_tmo = 1'b0;
      if (m_busy == 1 && (m_kind == K_ALU || m_kind == K_LI))
        m_ret++;
      if (m_busy == 2) begin
        if (mem_done) begin
          m_ret++;
          m_busy = 0;
        end else if (m_age == TO) begin
          m_tmo = 1'b1;
          m_busy = 0;
        end else begin
          m_age++;
        end
      end else if (acc) begin
        m_opc = instruction[20:17];
        m_op1 = instruction[16:14];
        m_op2 = instruction[13:11];
        m_op3 = instruction[10:8];
        m_imm = instruction[7:0];
        m_kind = classify(int'(m_opc));
        m_busy = (m_kind == K_MRD || m_kind == K_MWR) ? 2 : 1;
        m_age = 1;
      end else begin
        m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [20:0] ins);
    instruction = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_retired", retired_count, 16'd0);
    chk("rst_opcode", opcode, 4'd0);
    rst_n = 1'b1;
    tick();

    // warm up, then reset mid-run
    issue(21'h1100FF);
    tick();
    chk("pre_rst_retired", retired_count, 16'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_retired", retired_count, 16'd0);
    chk("midrst_imm", load_immediate_data, 8'h00);
    rst_n = 1'b1;
    tick();

    issue(21'h005300);
    chk("alu_en_1", alu_enable, 1'b1);
    chk("alu_ops", {op1, op2, op3}, {3'd1, 3'd2, 3'd3});
    tick();
    chk("alu_en_0", alu_enable, 1'b0);
    chk("alu_retired", retired_count, 16'd1);

    instr_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      instruction = {4'(i), 17'h0};
      chk("b2b_ready", instr_ready, 1'b1);
      tick();
      chk("b2b_alu", alu_enable, 1'b1);
      chk("b2b_opc", opcode, 4'(i));
    end
    instr_valid = 1'b0;
    tick();
    chk("b2b_alu_off", alu_enable, 1'b0);
    chk("b2b_retired", retired_count, 16'd4);

    issue(21'h1140A5);
    chk("li_en", load_immediate_enable, 1'b1);
    chk("li_op1", op1, 3'd5);
    chk("li_imm", load_immediate_data, 8'hA5);
    tick();
    chk("li_off", load_immediate_enable, 1'b0);
    chk("li_retired", retired_count, 16'd5);

    issue(21'h12A000);
    for (int i = 1; i <= 4; i++) begin
      chk("mrd_en", memory_read_enable, 1'b1);
      chk("mrd_ready", instr_ready, 1'b0);
      if (i == 4) mem_done = 1'b1;
      tick();
    end
    mem_done = 1'b0;
    chk("mrd_off", memory_read_enable, 1'b0);
    chk("mrd_retired", retired_count, 16'd6);
    chk("mrd_no_tmo", mem_timeout, 1'b0);

    issue(21'h140000);
    for (int i = 1; i <= TO; i++) begin
      chk("mwr_en", memory_write_enable, 1'b1);
      tick();
    end
    chk("mwr_off", memory_write_enable, 1'b0);
    chk("mwr_tmo", mem_timeout, 1'b1);
    chk("mwr_ready", instr_ready, 1'b1);
    chk("mwr_retired", retired_count, 16'd6);
    tick();
    chk("mwr_tmo_end", mem_timeout, 1'b0);

    issue(21'h0E0000);
    chk("ill_pulse", illegal_op, 1'b1);
    chk("ill_no_en", {alu_enable, load_immediate_enable,
        memory_read_enable, memory_write_enable}, 4'b0000);
    tick();
    chk("ill_end", illegal_op, 1'b0);
    chk("ill_retired", retired_count, 16'd6);

    issue(21'h12A000);
    tick();
    chk("pre_rst_rd", memory_read_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_rd_drop", memory_read_enable, 1'b0);
    chk("rst_ready_up", instr_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_no_tmo", mem_timeout, 1'b0);
    chk("rst_cnt_clr", retired_count, 16'd0);

    for (int i = 0; i < 3000; i++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      instruction = {4'($urandom_range(0, 15)), 17'($urandom)};
      mem_done = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    instr_valid = 1'b0;
    mem_done = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
